// File: rtl/funcq_operand_packer_if.sv
// funcq_operand_packer_if
// Bundles the word-stream handshake on the input side and the operand group
// presented to funcQ on the output side.
//   in_vld/in_rdy/in_sof/in_data : serial signed word stream (valid/ready)
//   data_vld, a, b, c, d         : single-cycle group pulse and held operands
//   drop_cnt                     : saturating count of discarded partial groups
//   busy                         : a group is partially collected or pending
// master : the word producer (and funcQ-side observer)
// slave  : the packer itself
interface funcq_operand_packer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
);
  logic                         in_vld;
  logic                         in_rdy;
  logic                         in_sof;
  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         data_vld;
  logic signed [DATA_WIDTH-1:0] a;
  logic signed [DATA_WIDTH-1:0] b;
  logic signed [DATA_WIDTH-1:0] c;
  logic signed [DATA_WIDTH-1:0] d;
  logic [CNT_WIDTH-1:0]         drop_cnt;
  logic                         busy;

  modport master (
    output in_vld, in_sof, in_data,
    input  in_rdy, data_vld, a, b, c, d, drop_cnt, busy
  );

  modport slave (
    input  in_vld, in_sof, in_data,
    output in_rdy, data_vld, a, b, c, d, drop_cnt, busy
  );
endinterface

// File: rtl/funcq_operand_packer.sv
// funcq_operand_packer
// Collects runs of four signed words into one a,b,c,d operand group and
// presents it to funcQ as a one-cycle data_vld pulse. funcQ cannot stall, so
// consecutive pulses are spaced at least MIN_GAP cycles apart by stalling the
// input side instead. An accepted in_sof in the middle of a group discards the
// partial group and restarts collection with that word as slot 0.
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of funcq_operand_packer_if (stream in, group out)
module funcq_operand_packer #(
  parameter int DATA_WIDTH = 16,
  parameter int MIN_GAP    = 1,
  parameter int CNT_WIDTH  = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  funcq_operand_packer_if.slave bus
);

  typedef enum logic {
    COLLECT = 1'b0,
    PEND    = 1'b1
  } state_e;

  // Value loaded into the gap counter on each emission; a zero counter means
  // the next group may be emitted on the very next edge.
  localparam logic [7:0] GAP_LOAD = 8'(MIN_GAP - 1);

  state_e                       state_q;
  logic [1:0]                   idx_q;
  logic [7:0]                   gap_q;
  logic signed [DATA_WIDTH-1:0] stage_q [4];
  logic signed [DATA_WIDTH-1:0] a_q, b_q, c_q, d_q;
  logic                         vld_q;
  logic [CNT_WIDTH-1:0]         drop_q;
  logic                         accept;

  assign bus.in_rdy = rst_n && (state_q == COLLECT);
  assign accept     = bus.in_vld && bus.in_rdy;

  // Collection, resync, gap pacing and emission share one register block so
  // the emission edge can reload the gap counter over the plain decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      idx_q   <= 2'd0;
      gap_q   <= 8'd0;
      for (int i = 0; i < 4; i++) stage_q[i] <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      vld_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      vld_q <= 1'b0;
      if (gap_q != 8'd0) gap_q <= gap_q - 8'd1;

      if (state_q == COLLECT) begin
        if (accept) begin
          if (bus.in_sof && (idx_q != 2'd0)) begin
            // Mid-group start-of-frame: drop what was collected and
            // restart with this word as slot 0.
            stage_q[0] <= bus.in_data;
            idx_q      <= 2'd1;
            if (drop_q != '1) drop_q <= drop_q + CNT_WIDTH'(1);
          end else begin
            stage_q[idx_q] <= bus.in_data;
            idx_q          <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              if (gap_q == 8'd0) begin
                // Emit on the same edge; slot 3 goes straight to d.
                a_q   <= stage_q[0];
                b_q   <= stage_q[1];
                c_q   <= stage_q[2];
                d_q   <= bus.in_data;
                vld_q <= 1'b1;
                gap_q <= GAP_LOAD;
              end else begin
                state_q <= PEND;
              end
            end
          end
        end
      end else begin
        // Input is stalled here; release the staged group once the spacing
        // from the previous pulse has elapsed.
        if (gap_q == 8'd0) begin
          a_q     <= stage_q[0];
          b_q     <= stage_q[1];
          c_q     <= stage_q[2];
          d_q     <= stage_q[3];
          vld_q   <= 1'b1;
          gap_q   <= GAP_LOAD;
          state_q <= COLLECT;
        end
      end
    end
  end

  assign bus.data_vld = vld_q;
  assign bus.a        = a_q;
  assign bus.b        = b_q;
  assign bus.c        = c_q;
  assign bus.d        = d_q;
  assign bus.drop_cnt = drop_q;
  assign bus.busy     = (idx_q != 2'd0) || (state_q == PEND);

endmodule

// File: tb/tb_funcq_operand_packer.sv
// tb_funcq_operand_packer
// Drives two packers, one with MIN_GAP=1 (instance 0) and one with MIN_GAP=8
// (instance 1), from directed word sequences. A reference model tracks the
// collected words, dropped groups and the earliest legal pulse time of each
// instance, and every falling edge the DUT outputs are compared against it.
// Literal expectations after each sequence pin the observed pulse values,
// counts and spacing.
module tb_funcq_operand_packer;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  // Per-instance stimulus
  logic               inVld  [2];
  logic               inSof  [2];
  logic signed [15:0] inData [2];

  // Per-instance observed outputs
  logic               inRdyO   [2];
  logic               dataVldO [2];
  logic signed [15:0] opO      [2][4];
  logic [7:0]         dropO    [2];
  logic               busyO    [2];

  funcq_operand_packer_if #(.DATA_WIDTH(16), .CNT_WIDTH(8)) busA ();
  funcq_operand_packer_if #(.DATA_WIDTH(16), .CNT_WIDTH(8)) busB ();

  funcq_operand_packer #(.DATA_WIDTH(16), .MIN_GAP(1), .CNT_WIDTH(8)) dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busA)
  );

  funcq_operand_packer #(.DATA_WIDTH(16), .MIN_GAP(8), .CNT_WIDTH(8)) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busB)
  );

  assign busA.in_vld  = inVld[0];
  assign busA.in_sof  = inSof[0];
  assign busA.in_data = inData[0];
  assign busB.in_vld  = inVld[1];
  assign busB.in_sof  = inSof[1];
  assign busB.in_data = inData[1];

  assign inRdyO[0]   = busA.in_rdy;
  assign dataVldO[0] = busA.data_vld;
  assign opO[0][0]   = busA.a;
  assign opO[0][1]   = busA.b;
  assign opO[0][2]   = busA.c;
  assign opO[0][3]   = busA.d;
  assign dropO[0]    = busA.drop_cnt;
  assign busyO[0]    = busA.busy;
  assign inRdyO[1]   = busB.in_rdy;
  assign dataVldO[1] = busB.data_vld;
  assign opO[1][0]   = busB.a;
  assign opO[1][1]   = busB.b;
  assign opO[1][2]   = busB.c;
  assign opO[1][3]   = busB.d;
  assign dropO[1]    = busB.drop_cnt;
  assign busyO[1]    = busB.busy;

  // Clock: rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int                 edgeNo;
  int                 wordCnt  [2];
  logic signed [15:0] staged   [2][4];
  bit                 pending  [2];
  int                 emitAt   [2];
  int                 lastEmit [2];
  logic signed [15:0] expOp    [2][4];
  bit                 expVld   [2];
  int                 expDrop  [2];

  // Pulse log and stall accounting for literal checks
  int                 pulseCnt  [2];
  int                 pulseEdge [2][16];
  logic signed [15:0] pulseVal  [2][16][4];
  int                 rdyLow    [2];

  function automatic int minGapOf(input int inst);
    return (inst == 0) ? 1 : 8;
  endfunction

  task modelReset();
    for (int i = 0; i < 2; i++) begin
      wordCnt[i]  = 0;
      pending[i]  = 1'b0;
      emitAt[i]   = 0;
      lastEmit[i] = -1000;
      expVld[i]   = 1'b0;
      expDrop[i]  = 0;
      for (int k = 0; k < 4; k++) begin
        staged[i][k] = '0;
        expOp[i][k]  = '0;
      end
    end
  endtask

  task modelEmit(input int inst);
    for (int k = 0; k < 4; k++) expOp[inst][k] = staged[inst][k];
    expVld[inst]   = 1'b1;
    lastEmit[inst] = edgeNo;
    pending[inst]  = 1'b0;
  endtask

  // One rising edge of the model: a group becomes visible at the later of the
  // edge completing it and MIN_GAP edges after the previous pulse.
  task modelStep();
    int earliest;
    edgeNo++;
    for (int i = 0; i < 2; i++) begin
      expVld[i] = 1'b0;
      if (pending[i]) begin
        if (edgeNo == emitAt[i]) modelEmit(i);
      end else if (inVld[i]) begin
        if (inSof[i] && wordCnt[i] != 0) begin
          wordCnt[i] = 0;
          if (expDrop[i] < 255) expDrop[i]++;
        end
        staged[i][wordCnt[i]] = inData[i];
        wordCnt[i]++;
        if (wordCnt[i] == 4) begin
          wordCnt[i] = 0;
          earliest = lastEmit[i] + minGapOf(i);
          if (earliest <= edgeNo) begin
            modelEmit(i);
          end else begin
            pending[i] = 1'b1;
            emitAt[i]  = earliest;
          end
        end
      end
    end
  endtask

  initial begin
    edgeNo = 0;
    modelReset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) modelReset();
      else        modelStep();
    end
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task clearLog();
    for (int i = 0; i < 2; i++) begin
      pulseCnt[i] = 0;
      rdyLow[i]   = 0;
    end
  endtask

  // Compare process: every falling edge, all outputs of both instances.
  initial begin
    clearLog();
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        checkOutput($sformatf("inst%0d.in_rdy", i), int'(inRdyO[i]),
                    int'(rst_n && !pending[i]));
        checkOutput($sformatf("inst%0d.data_vld", i), int'(dataVldO[i]), int'(expVld[i]));
        for (int k = 0; k < 4; k++)
          checkOutput($sformatf("inst%0d.op%0d", i, k), int'(opO[i][k]), int'(expOp[i][k]));
        checkOutput($sformatf("inst%0d.drop_cnt", i), int'(dropO[i]), expDrop[i]);
        checkOutput($sformatf("inst%0d.busy", i), int'(busyO[i]),
                    int'(rst_n && (wordCnt[i] != 0 || pending[i])));
        if (dataVldO[i] && pulseCnt[i] < 16) begin
          pulseEdge[i][pulseCnt[i]] = edgeNo;
          for (int k = 0; k < 4; k++) pulseVal[i][pulseCnt[i]][k] = opO[i][k];
          pulseCnt[i]++;
        end
        if (rst_n && !inRdyO[i]) rdyLow[i]++;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus (called just after a rising edge)
  // ---------------------------------------------------------------------------
  task applyStimulus(input int inst, input logic signed [15:0] word, input logic sof);
    bit done;
    int waitCnt;
    inVld[inst]  = 1'b1;
    inSof[inst]  = sof;
    inData[inst] = word;
    done    = 1'b0;
    waitCnt = 0;
    while (!done && waitCnt < 64) begin
      @(negedge clk);
      if (inRdyO[inst]) done = 1'b1;
      @(posedge clk);
      #1;
      waitCnt++;
    end
    inVld[inst] = 1'b0;
    inSof[inst] = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL acceptTimeout inst%0d actual=notAccepted expected=accepted word=%0d", inst, word);
    end
  endtask

  task idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task checkGroup(input string name, input int inst, input int p,
                  input int ea, input int eb, input int ec, input int ed);
    checkOutput({name, ".a"}, int'(pulseVal[inst][p][0]), ea);
    checkOutput({name, ".b"}, int'(pulseVal[inst][p][1]), eb);
    checkOutput({name, ".c"}, int'(pulseVal[inst][p][2]), ec);
    checkOutput({name, ".d"}, int'(pulseVal[inst][p][3]), ed);
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      inVld[i]  = 1'b1;
      inSof[i]  = 1'b1;
      inData[i] = 16'sh0055;
    end
    rst_n = 1'b0;

    // Reset held for 10 cycles with valid asserted
    repeat (10) @(posedge clk);
    @(negedge clk);
    checkOutput("resetRdy", int'(inRdyO[0]), 0);
    checkOutput("resetVld", int'(dataVldO[1]), 0);
    checkOutput("resetA", int'(opO[0][0]), 0);
    checkOutput("resetDrop", int'(dropO[1]), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      inVld[i] = 1'b0;
      inSof[i] = 1'b0;
    end
    @(negedge clk);
    checkOutput("rdyAfterReset0", int'(inRdyO[0]), 1);
    checkOutput("rdyAfterReset1", int'(inRdyO[1]), 1);
    @(posedge clk);
    #1;

    // Back-to-back groups, MIN_GAP=1
    $display("[TB] back-to-back groups");
    clearLog();
    applyStimulus(0, 16'sd11, 1'b1);
    applyStimulus(0, 16'sd5, 1'b0);
    applyStimulus(0, -16'sd1, 1'b0);
    applyStimulus(0, 16'sd5, 1'b0);
    applyStimulus(0, 16'sd12, 1'b1);
    applyStimulus(0, 16'sd3, 1'b0);
    applyStimulus(0, -16'sd2, 1'b0);
    applyStimulus(0, 16'sd1, 1'b0);
    idleCycles(3);
    checkOutput("b2b.pulses", pulseCnt[0], 2);
    checkGroup("b2b.g0", 0, 0, 11, 5, -1, 5);
    checkGroup("b2b.g1", 0, 1, 12, 3, -2, 1);
    checkOutput("b2b.spacing", pulseEdge[0][1] - pulseEdge[0][0], 4);

    // Gap stall, MIN_GAP=8
    $display("[TB] gap stall");
    clearLog();
    for (int w = 1; w <= 8; w++)
      applyStimulus(1, 16'(w), (w == 1 || w == 5));
    idleCycles(12);
    checkOutput("stall.pulses", pulseCnt[1], 2);
    checkOutput("stall.spacing", pulseEdge[1][1] - pulseEdge[1][0], 8);
    checkOutput("stall.rdyLowCycles", rdyLow[1], 4);
    checkGroup("stall.g0", 1, 0, 1, 2, 3, 4);
    checkGroup("stall.g1", 1, 1, 5, 6, 7, 8);

    // Resync on a mid-group start-of-frame
    $display("[TB] resync");
    clearLog();
    applyStimulus(0, 16'sd7, 1'b1);
    applyStimulus(0, 16'sd8, 1'b0);
    applyStimulus(0, 16'sd1, 1'b1);
    applyStimulus(0, 16'sd2, 1'b0);
    applyStimulus(0, 16'sd3, 1'b0);
    applyStimulus(0, 16'sd4, 1'b0);
    idleCycles(3);
    checkOutput("resync.drop", int'(dropO[0]), 1);
    checkOutput("resync.pulses", pulseCnt[0], 1);
    checkGroup("resync.g0", 0, 0, 1, 2, 3, 4);

    // Idle gaps between words, extreme values
    $display("[TB] idle gaps");
    clearLog();
    applyStimulus(0, -16'sd3, 1'b1);
    idleCycles(2);
    applyStimulus(0, 16'sd0, 1'b0);
    idleCycles(2);
    applyStimulus(0, 16'sd32767, 1'b0);
    idleCycles(2);
    applyStimulus(0, 16'sh8000, 1'b0);
    idleCycles(3);
    checkOutput("idle.pulses", pulseCnt[0], 1);
    checkGroup("idle.g0", 0, 0, -3, 0, 32767, -32768);

    // Reset in the middle of a group
    $display("[TB] reset mid-group");
    clearLog();
    applyStimulus(0, 16'sd5, 1'b1);
    applyStimulus(0, 16'sd6, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int w = 0; w < 4; w++)
      applyStimulus(0, 16'sd9, (w == 0));
    idleCycles(3);
    checkOutput("rstMid.pulses", pulseCnt[0], 1);
    checkOutput("rstMid.drop", int'(dropO[0]), 0);
    checkGroup("rstMid.g0", 0, 0, 9, 9, 9, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
